// File: rtl/imem_loader.sv
// imem_loader: loads an N-word program from a byte stream into a word RAM, then serves registered fetches.
// Optional feature macro IMEM_CHECKSUM_EN: a trailing XOR checksum byte must follow the data words.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  output logic        core_run,
  output logic        load_err
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
`ifdef IMEM_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt;
  logic [7:0]        n_lo_r;
  logic [ADDR_W-1:0] wp_r;
  logic [ADDR_W-1:0] last_idx_r;
  logic [1:0]        bl_r;
  logic [23:0]       word_r;
  logic [15:0]       last_pc_r;
  logic              core_run_r;
  logic              load_err_r;
  logic [31:0]       instr_data_r;
  logic [31:0]       mem [2**ADDR_W];
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]        csum_r;
`endif

  logic        accept_s;
  logic        hdr_bad_s;
  logic        last_word_s;
  logic        wr_en_s;
  logic        addr_ok_s;
  logic [15:0] hdr_n_s;
  logic [31:0] word_s;

  assign accept_s    = in_valid && in_ready;
  assign hdr_n_s     = {in_data, n_lo_r};
  assign hdr_bad_s   = (hdr_n_s == 16'd0) || ({1'b0, hdr_n_s} > DEPTH);
  assign word_s      = {in_data, word_r};
  assign last_word_s = (bl_r == 2'd3) && (wp_r == last_idx_r);
  assign wr_en_s     = accept_s && (state_r == DATA) && (bl_r == 2'd3);
  assign addr_ok_s   = (instr_addr[31:ADDR_W] == {(32-ADDR_W){1'b0}});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HDR0;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode; in_ready depends on the state alone
  always_comb begin
    state_nxt = state_r;
    in_ready  = 1'b0;
    case (state_r)
      HDR0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HDR1;
        else          state_nxt = HDR0;
      end
      HDR1: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = hdr_bad_s ? ERR : DATA;
        else          state_nxt = HDR1;
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && last_word_s) begin
`ifdef IMEM_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = RUN;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef IMEM_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum_r) ? RUN : ERR;
        else          state_nxt = CSUM;
      end
`endif
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  // Header capture, byte assembly, status flags and fetch register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lo_r       <= 8'd0;
      wp_r         <= {ADDR_W{1'b0}};
      last_idx_r   <= {ADDR_W{1'b0}};
      bl_r         <= 2'd0;
      word_r       <= 24'd0;
      last_pc_r    <= 16'd0;
      core_run_r   <= 1'b0;
      load_err_r   <= 1'b0;
      instr_data_r <= NOP;
`ifdef IMEM_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      core_run_r <= (state_nxt == RUN);
      load_err_r <= (state_nxt == ERR);
      if ((state_r == RUN) && addr_ok_s) instr_data_r <= mem[instr_addr[ADDR_W-1:0]];
      else                               instr_data_r <= NOP;
      if (accept_s) begin
        case (state_r)
          HDR0: n_lo_r <= in_data;
          HDR1: begin
            // N-1 always fits ADDR_W bits once the header passes the range check
            if (!hdr_bad_s) begin
              last_pc_r  <= hdr_n_s - 16'd1;
              last_idx_r <= ADDR_W'(hdr_n_s - 16'd1);
            end
            wp_r <= {ADDR_W{1'b0}};
            bl_r <= 2'd0;
`ifdef IMEM_CHECKSUM_EN
            csum_r <= 8'd0;
`endif
          end
          DATA: begin
            case (bl_r)
              2'd0:    word_r[7:0]   <= in_data;
              2'd1:    word_r[15:8]  <= in_data;
              2'd2:    word_r[23:16] <= in_data;
              default: wp_r <= wp_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            endcase
            bl_r <= bl_r + 2'd1;
`ifdef IMEM_CHECKSUM_EN
            csum_r <= csum_r ^ in_data;
`endif
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Word RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wp_r] <= word_s;
  end

  assign instr_data = instr_data_r;
  assign last_pc    = {16'd0, last_pc_r};
  assign core_run   = core_run_r;
  assign load_err   = load_err_r;

endmodule
